// File: rtl/cpstr_mgr_rx_if.sv
// Byte-stream bundle for the control-port receive demux: muxed input side,
// per-lane output side and stream-index status.
interface cpstr_mgr_rx_if #(
  parameter int NUM_STREAMS = 2
);
  logic [7:0]               i_data;
  logic                     i_valid;
  logic                     o_ready;
  logic [8*NUM_STREAMS-1:0] o_data;
  logic [NUM_STREAMS-1:0]   o_valid;
  logic [NUM_STREAMS-1:0]   i_ready;
  logic [7:0]               o_stridx;
  logic                     o_stridx_vld;
  logic                     o_err_stridx;
  logic                     o_drop;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_stridx, o_stridx_vld, o_err_stridx, o_drop
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_stridx, o_stridx_vld, o_err_stridx, o_drop
  );
endinterface

// File: rtl/cpstr_mgr_rx.sv
// Receive-side demux for the escaped control-port byte stream: strips escapes
// and steers payload bytes to the lane picked by the last {ESC_CHAR, idx}.
//
// state  | meaning
// S_DATA | next byte is payload, or ESC_CHAR opening an escape
// S_ESC  | ESC_CHAR seen; next byte is a literal ESC_CHAR or a stream index
module cpstr_mgr_rx #(
  parameter int         NUM_STREAMS = 2,
  parameter logic [7:0] ESC_CHAR    = 8'hDB
) (
  input  logic           clk,
  input  logic           rst,
  cpstr_mgr_rx_if.slave  bus
);
  localparam int         TW  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam logic [7:0] NS8 = 8'(NUM_STREAMS);

  typedef enum logic {S_DATA, S_ESC} state_t;

  state_t          state_q, state_d;
  logic            full_q;
  logic [7:0]      data_q;
  logic [TW-1:0]   tag_q;
  logic [7:0]      stridx_q;
  logic            stridx_vld_q;
  logic            err_q;
  logic            drop_q;

  logic            accept;
  logic            drain;
  logic            payload;
  logic            idx_ok;
  logic            idx_bad;

  assign drain       = full_q && bus.i_ready[tag_q];
  assign bus.o_ready = !full_q || bus.i_ready[tag_q];
  assign accept      = bus.i_valid && bus.o_ready;

  always_comb begin
    state_d = state_q;
    payload = 1'b0;
    idx_ok  = 1'b0;
    idx_bad = 1'b0;
    if (accept) begin
      case (state_q)
        S_DATA: begin
          if (bus.i_data == ESC_CHAR) state_d = S_ESC;
          else                        payload = 1'b1;
        end
        S_ESC: begin
          state_d = S_DATA;
          if (bus.i_data == ESC_CHAR)  payload = 1'b1;
          else if (bus.i_data < NS8)   idx_ok  = 1'b1;
          else                         idx_bad = 1'b1;
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_DATA;
      full_q       <= 1'b0;
      data_q       <= '0;
      tag_q        <= '0;
      stridx_q     <= '0;
      stridx_vld_q <= 1'b0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= idx_bad;
      drop_q  <= payload && !stridx_vld_q;
      // The tag is frozen at capture, so an index escape landing on the drain
      // cycle only affects later bytes.
      if (payload && stridx_vld_q) begin
        full_q <= 1'b1;
        data_q <= bus.i_data;
        tag_q  <= stridx_q[TW-1:0];
      end else if (drain) begin
        full_q <= 1'b0;
      end
      if (idx_ok) begin
        stridx_q     <= bus.i_data;
        stridx_vld_q <= 1'b1;
      end else if (idx_bad) begin
        stridx_vld_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.o_valid = '0;
    if (full_q) bus.o_valid[tag_q] = 1'b1;
  end

  assign bus.o_data       = {NUM_STREAMS{data_q}};
  assign bus.o_stridx     = stridx_q;
  assign bus.o_stridx_vld = stridx_vld_q;
  assign bus.o_err_stridx = err_q;
  assign bus.o_drop       = drop_q;
endmodule
